// File: rtl/cpu_pkg.sv
// Shared CPU definitions: MEM-stage FSM encoding, alignment mask, defaults.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam logic [31:0] WORD_ALIGN_MASK      = 32'hFFFF_FFFC;
  localparam int unsigned TIMEOUT_CYCLES_DEF   = 64;
  localparam logic [31:0] ERR_DATA_DEF         = 32'h0000_0000;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating 8-bit wait counter with clear/enable; expired_o flags the last
// permitted wait cycle (count == LIMIT-1). LIMIT must be 1..256.
module mem_timeout_ctr #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + 8'd1;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: turns MemRead/MemWrite into a req/ack
// access, stalls the pipeline while it is outstanding, flags misalignment
// and bus timeouts, and presents load data to MEM/WB.
module mem_stage_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  input  logic        Hold_i,
  output logic        stall_o,
  output logic [31:0] MemData_o,
  output logic        AddrErr_o,
  output logic        BusErr_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  mem_state_e  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic        buserr_q, buserr_d;
  logic        access, misaligned, expired;

  assign access     = MemRead_i | MemWrite_i;
  assign misaligned = access & (Addr_i[1:0] != 2'b00);

  mem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_q != WAIT),
    .en_i      ((state_q == WAIT) & ~mem_ack_i),
    .expired_o (expired)
  );

  // Next-state, request capture, result capture and stall generation.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    buserr_d = 1'b0;
    stall_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access && !misaligned) begin
          stall_o = 1'b1;
          state_d = WAIT;
          req_d   = 1'b1;
          we_d    = MemWrite_i;
          addr_d  = Addr_i & WORD_ALIGN_MASK;
          wdata_d = WriteData_i;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) data_d = mem_rdata_i;
        end else if (expired) begin
          state_d  = DONE;
          req_d    = 1'b0;
          buserr_d = 1'b1;
          if (!we_q) data_d = ERR_DATA;
        end
      end
      DONE: begin
        if (!Hold_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered state and memory-side outputs; reset abandons any access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      buserr_q <= buserr_d;
    end
  end

  assign AddrErr_o   = misaligned;
  assign MemData_o   = ((state_q == IDLE) && misaligned && MemRead_i) ? ERR_DATA : data_q;
  assign BusErr_o    = buserr_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl.
module tb_mem_stage_ctrl;
  import cpu_pkg::*;

  localparam int unsigned TO  = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst, MemRead, MemWrite, Hold, ack;
  logic [31:0] Addr, WriteData, rdata;
  logic        stall, AddrErr, BusErr, req, we;
  logic [31:0] MemData, maddr, mwdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .ERR_DATA       (ERR)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .MemRead_i   (MemRead),
    .MemWrite_i  (MemWrite),
    .Addr_i      (Addr),
    .WriteData_i (WriteData),
    .Hold_i      (Hold),
    .stall_o     (stall),
    .MemData_o   (MemData),
    .AddrErr_o   (AddrErr),
    .BusErr_o    (BusErr),
    .mem_req_o   (req),
    .mem_we_o    (we),
    .mem_addr_o  (maddr),
    .mem_wdata_o (mwdata),
    .mem_ack_i   (ack),
    .mem_rdata_i (rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Hold = 1'b0; ack = 1'b0;
    Addr = '0; WriteData = '0; rdata = '0;
    tick(); tick();
    // Reset state
    chk("rst_req",    32'(req),    32'd0);
    chk("rst_we",     32'(we),     32'd0);
    chk("rst_addr",   maddr,       32'd0);
    chk("rst_wdata",  mwdata,      32'd0);
    chk("rst_data",   MemData,     32'd0);
    chk("rst_buserr", 32'(BusErr), 32'd0);
    chk("rst_stall",  32'(stall),  32'd0);
    chk("rst_state",  32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    tick();

    // Load 0x10, ack in first WAIT cycle
    MemRead = 1'b1; Addr = 32'h0000_0010; #1;
    chk("ld_idle_stall", 32'(stall), 32'd1);
    chk("ld_idle_req",   32'(req),   32'd0);
    tick();
    chk("ld_wait_state", 32'(dut.state_q), 32'(WAIT));
    chk("ld_wait_req",   32'(req),   32'd1);
    chk("ld_wait_we",    32'(we),    32'd0);
    chk("ld_wait_addr",  maddr,      32'h0000_0010);
    chk("ld_wait_stall", 32'(stall), 32'd1);
    ack = 1'b1; rdata = 32'hCAFE_F00D;
    tick();
    ack = 1'b0; rdata = '0; #1;
    chk("ld_done_state", 32'(dut.state_q), 32'(DONE));
    chk("ld_done_stall", 32'(stall), 32'd0);
    chk("ld_done_req",   32'(req),   32'd0);
    chk("ld_done_data",  MemData,    32'hCAFE_F00D);
    tick();
    MemRead = 1'b0; #1;
    chk("ld_back_idle", 32'(dut.state_q), 32'(IDLE));

    // Store 0x20, ack in third WAIT cycle
    MemWrite = 1'b1; Addr = 32'h0000_0020; WriteData = 32'h1234_5678; #1;
    chk("st_idle_stall", 32'(stall), 32'd1);
    tick();
    chk("st_w1_req",   32'(req),   32'd1);
    chk("st_w1_we",    32'(we),    32'd1);
    chk("st_w1_wdata", mwdata,     32'h1234_5678);
    chk("st_w1_addr",  maddr,      32'h0000_0020);
    tick();
    chk("st_w2_stall", 32'(stall), 32'd1);
    tick();
    chk("st_w3_stall", 32'(stall), 32'd1);
    ack = 1'b1; rdata = 32'hFFFF_FFFF;
    tick();
    ack = 1'b0; #1;
    chk("st_done_stall", 32'(stall), 32'd0);
    chk("st_done_req",   32'(req),   32'd0);
    chk("st_done_data",  MemData,    32'hCAFE_F00D);
    tick();
    MemWrite = 1'b0; #1;

    // Misaligned load
    MemRead = 1'b1; Addr = 32'h0000_0013; #1;
    chk("mis_addrerr", 32'(AddrErr), 32'd1);
    chk("mis_stall",   32'(stall),   32'd0);
    chk("mis_data",    MemData,      ERR);
    tick();
    chk("mis_req",   32'(req), 32'd0);
    chk("mis_state", 32'(dut.state_q), 32'(IDLE));
    MemRead = 1'b0; #1;
    chk("mis_clear_err",  32'(AddrErr), 32'd0);
    chk("mis_clear_data", MemData,      32'hCAFE_F00D);

    // Load timeout (TIMEOUT_CYCLES=4): four WAIT cycles, then DONE with BusErr
    MemRead = 1'b1; Addr = 32'h0000_0040;
    tick();
    tick(); tick(); tick();
    chk("to_w4_state",  32'(dut.state_q), 32'(WAIT));
    chk("to_w4_buserr", 32'(BusErr), 32'd0);
    tick();
    chk("to_done_state",  32'(dut.state_q), 32'(DONE));
    chk("to_done_buserr", 32'(BusErr), 32'd1);
    chk("to_done_data",   MemData,     ERR);
    chk("to_done_req",    32'(req),    32'd0);
    MemRead = 1'b0;
    tick();
    chk("to_buserr_pulse", 32'(BusErr), 32'd0);
    tick();
    ack = 1'b1; rdata = 32'h5555_5555;
    tick();
    ack = 1'b0; #1;
    chk("late_ack_state", 32'(dut.state_q), 32'(IDLE));
    chk("late_ack_req",   32'(req),   32'd0);
    chk("late_ack_data",  MemData,    ERR);

    // Load acked, Hold_i for 3 DONE cycles
    MemRead = 1'b1; Addr = 32'h0000_0080;
    tick();
    ack = 1'b1; rdata = 32'hA5A5_0001;
    tick();
    ack = 1'b0; Hold = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold_state", 32'(dut.state_q), 32'(DONE));
      chk("hold_req",   32'(req),   32'd0);
      chk("hold_data",  MemData,    32'hA5A5_0001);
      chk("hold_stall", 32'(stall), 32'd0);
    end
    Hold = 1'b0;
    tick();
    MemRead = 1'b0; #1;
    chk("hold_release_state", 32'(dut.state_q), 32'(IDLE));
    chk("hold_release_req",   32'(req), 32'd0);

    // Reset in the second WAIT cycle of a store
    MemWrite = 1'b1; Addr = 32'h0000_0100; WriteData = 32'h0BAD_F00D;
    tick();
    tick();
    chk("rw_w2_state", 32'(dut.state_q), 32'(WAIT));
    rst = 1'b1; MemWrite = 1'b0;
    tick();
    chk("rw_state", 32'(dut.state_q), 32'(IDLE));
    chk("rw_req",   32'(req),   32'd0);
    chk("rw_data",  MemData,    32'd0);
    chk("rw_stall", 32'(stall), 32'd0);
    chk("rw_addr",  maddr,      32'd0);
    rst = 1'b0; ack = 1'b1; rdata = 32'h7777_7777;
    tick();
    ack = 1'b0; #1;
    chk("rw_late_ack_state", 32'(dut.state_q), 32'(IDLE));
    chk("rw_late_ack_data",  MemData, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage data-memory access controller between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Converts the single-cycle MemRead/MemWrite intent into a req/ack handshake with a variable-latency data memory.
- Freezes the pipeline while an access is outstanding and presents the load data as MemData_o for MEM/WB to capture.
- Detects misaligned addresses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 64: maximum number of WAIT cycles without mem_ack_i before the access is aborted.
- ERR_DATA, 32'h0000_0000: value driven on MemData_o after an aborted or misaligned load.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous, active-high reset.
- MemRead_i  in  1  load request from EX/MEM.
- MemWrite_i  in  1  store request from EX/MEM.
- Addr_i  in  32  byte address (ALU result) from EX/MEM.
- WriteData_i  in  32  store data from EX/MEM.
- Hold_i  in  1  pipeline held by another hazard source this cycle.
- stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- MemData_o  out  32  load data to MEM/WB.
- AddrErr_o  out  1  misaligned access (combinational).
- BusErr_o  out  1  one-cycle pulse when an access times out.
- mem_req_o  out  1  memory request (registered).
- mem_we_o  out  1  1 = write (registered).
- mem_addr_o  out  32  word-aligned address (registered).
- mem_wdata_o  out  32  store data (registered).
- mem_ack_i  in  1  memory completion.
- mem_rdata_i  in  32  read data, valid with mem_ack_i.

Behaviour:
- Definitions:
  - access = MemRead_i | MemWrite_i.
  - misaligned = access & (Addr_i[1:0] != 0).
  - If MemRead_i and MemWrite_i are both 1, treat the access as a write.
- Reset (rst_i=1 at posedge), which overrides everything:
  - state = IDLE, counter = 0.
  - mem_req_o, mem_we_o, BusErr_o = 0.
  - mem_addr_o, mem_wdata_o, MemData_o = 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - stall_o = access & ~misaligned.
  - If access & ~misaligned, go to WAIT. Capture mem_addr_o = {Addr_i[31:2],2'b00}, mem_wdata_o = WriteData_i, mem_we_o = MemWrite_i. Set mem_req_o = 1 and counter = 0.
  - If misaligned, issue no request and leave stall_o = 0. AddrErr_o = 1 in the same cycle. MemData_o is combinationally forced to ERR_DATA while misaligned & MemRead_i.
- WAIT:
  - stall_o = 1; mem_req_o held at 1.
  - mem_ack_i=1: go to DONE and drop mem_req_o. For a read, MemData_o <= mem_rdata_i. For a write, MemData_o is unchanged.
  - mem_ack_i=0: counter++. When counter == TIMEOUT_CYCLES-1, go to DONE, drop mem_req_o, pulse BusErr_o for one cycle, and set MemData_o <= ERR_DATA if the access was a read.
- DONE:
  - stall_o = 0. MEM/WB captures MemData_o at the closing edge.
  - Hold_i=0: go to IDLE.
  - Hold_i=1: stay in DONE. EX/MEM still holds the same instruction, so it must not be re-issued; MemData_o is held.
- Latency:
  - Minimum 2 stall cycles per access: detect in IDLE, ack in the first WAIT cycle, then DONE.
  - In general, stall cycles = 1 + ack wait cycles.
- mem_ack_i outside WAIT is ignored, including a late ack after a timeout or reset.
- Reset mid-WAIT abandons the access. mem_req_o is 0 from the next cycle; no write-back occurs.
- Back-to-back accesses: DONE→IDLE, then the next EX/MEM instruction is detected in IDLE. No bubble is inserted beyond the FSM itself.
- The counter is 8 bits wide; TIMEOUT_CYCLES must be ≤ 256. The counter saturates and never wraps while in WAIT.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding: IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
  - WORD_ALIGN_MASK.
  - Default TIMEOUT_CYCLES and ERR_DATA.
- One sub-module, mem_timeout_ctr: saturating counter with clear/enable inputs and an expired output, reused later by the instruction-fetch controller.

Test Plan:
- Load Addr_i=32'h0000_0010, ack in the first WAIT cycle with rdata 32'hCAFE_F00D → stall_o high for 2 cycles, mem_addr_o=32'h10, mem_we_o=0, MemData_o=32'hCAFE_F00D in DONE.
- Store Addr_i=32'h20, WriteData_i=32'h1234_5678, ack after 3 WAIT cycles → stall_o high for 4 cycles, mem_we_o=1, mem_wdata_o=32'h1234_5678, MemData_o unchanged.
- Load Addr_i=32'h0000_0013 → mem_req_o stays 0, AddrErr_o=1, stall_o=0, MemData_o=ERR_DATA that cycle.
- Load with TIMEOUT_CYCLES=4 and no ack → BusErr_o pulses once entering DONE, MemData_o=0. An ack arriving 2 cycles later is ignored and the state stays IDLE.
- Load acked, Hold_i=1 for 3 cycles in DONE → state stays DONE, no new mem_req_o, MemData_o stable; returns to IDLE the cycle after Hold_i drops.
- rst_i asserted in the 2nd WAIT cycle → next cycle: state IDLE, mem_req_o=0, MemData_o=0, stall_o=0 if MemRead_i/MemWrite_i are also 0.
